button_debouncer: RTL and testbench

//  Debounces one mechanical push-button input using the periodic one-cycle sample strobe from the

---
 rtl/button_debouncer.sv | 175 +++++++++++++++++
 tb/tb_button_debouncer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - tick-sampled push-button debouncer with press/release/repeat events
// Optional auto-repeat: define BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 3,
  parameter int HOLD_TICKS   = 33,
  parameter int REPEAT_TICKS = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int MAX_A = (STABLE_TICKS > HOLD_TICKS) ? STABLE_TICKS : HOLD_TICKS;
  localparam int MAX_T = (MAX_A > REPEAT_TICKS) ? MAX_A : REPEAT_TICKS;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_TICKS);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  localparam logic [1:0] S_IDLE            = 2'd0;
  localparam logic [1:0] S_CONFIRM_PRESS   = 2'd1;
  localparam logic [1:0] S_HELD            = 2'd2;
  localparam logic [1:0] S_CONFIRM_RELEASE = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   btn_sync;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], btn_raw};
  assign btn_sync = sync_q[SYNC_STAGES-1];
  assign cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + ONE_C;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (btn_sync) begin
            if (STABLE_TICKS == 1) begin
              state_d = S_HELD;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              state_d = S_CONFIRM_PRESS;
              cnt_d   = ONE_C;
            end
          end
        end
        S_CONFIRM_PRESS: begin
          if (btn_sync) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= STABLE_C) begin
              state_d = S_HELD;
              cnt_d   = '0;
              press_d = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          if (!btn_sync) begin
            if (STABLE_TICKS == 1) begin
              state_d   = S_IDLE;
              cnt_d     = '0;
              release_d = 1'b1;
            end else begin
              state_d = S_CONFIRM_RELEASE;
              cnt_d   = ONE_C;
            end
          end
        end
        default: begin
          if (!btn_sync) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= STABLE_C) begin
              state_d   = S_IDLE;
              cnt_d     = '0;
              release_d = 1'b1;
            end
          end else begin
            state_d = S_HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
    level_d = press_d ? 1'b1 : (release_d ? 1'b0 : level_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam logic [CW-1:0] HOLD_C   = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_TICKS);

  logic [CW-1:0] hold_q, hold_d, hold_inc;
  logic          phase_q, phase_d;
  logic          repeat_q, repeat_d;

  assign hold_inc = hold_q + ONE_C;

  // phase_q=0 counts the initial hold delay, phase_q=1 counts repeat intervals
  always_comb begin
    hold_d   = hold_q;
    phase_d  = phase_q;
    repeat_d = 1'b0;
    if (press_d || state_d == S_IDLE) begin
      hold_d  = '0;
      phase_d = 1'b0;
    end else if (tick && state_q == S_HELD && state_d == S_HELD) begin
      if (!phase_q && hold_inc == HOLD_C) begin
        hold_d   = '0;
        phase_d  = 1'b1;
        repeat_d = 1'b1;
      end else if (phase_q && hold_inc == REPEAT_C) begin
        hold_d   = '0;
        repeat_d = 1'b1;
      end else begin
        hold_d = hold_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      phase_q  <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      phase_q  <= phase_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - table-driven bench for button_debouncer
module tb_button_debouncer;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic btn_raw;
  logic btn_level, press_pulse, release_pulse, repeat_pulse;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .SYNC_STAGES (2),
    .STABLE_TICKS(3),
    .HOLD_TICKS  (4),
    .REPEAT_TICKS(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] pat;
    int         lvl;
    int         np;
    int         nr;
    int         nrep;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [9:0] pat, input int lvl, input int np, input int nr, input int nrep);
    vec_t v;
    v.pat = pat; v.lvl = lvl; v.np = np; v.nr = nr; v.nrep = nrep;
    vecs.push_back(v);
  endtask

  // One tick period: 10 clk, btn_raw follows pat[i] per cycle, tick on cycle 4
  task automatic run_slot(input logic [9:0] pat, output int lvl, output int np, output int nr, output int nrep);
    np = 0; nr = 0; nrep = 0;
    for (int i = 0; i < 10; i++) begin
      btn_raw = pat[i];
      tick    = (i == 4);
      @(posedge clk); #1;
      np   += int'(press_pulse);
      nr   += int'(release_pulse);
      nrep += int'(repeat_pulse);
    end
    tick = 1'b0;
    lvl  = int'(btn_level);
  endtask

  task automatic slot_check(input string name, input logic [9:0] pat, input int lvl, input int np, input int nr);
    int al, ap, ar, arep;
    run_slot(pat, al, ap, ar, arep);
    check({name, "_level"}, al, lvl);
    check({name, "_press"}, ap, np);
    check({name, "_release"}, ar, nr);
  endtask

  always @(negedge clk) begin
    if (press_pulse && release_pulse) begin
      checks++;
      errors++;
      $display("FAIL both_pulses: got press=1 release=1 expected not both");
    end
  end

  initial begin
    int al, ap, ar, arep, rel_cnt;

    // press/release, release stays 3 zero-samples
    add(10'h3FF, 0, 0, 0, 0); add(10'h3FF, 0, 0, 0, 0); add(10'h3FF, 1, 1, 0, 0);
    for (int h = 1; h <= 3; h++) add(10'h3FF, 1, 0, 0, 0);
    add(10'h000, 1, 0, 0, 0); add(10'h000, 1, 0, 0, 0); add(10'h000, 0, 0, 1, 0);
    // press bounce
    add(10'h3FF, 0, 0, 0, 0); add(10'h3FF, 0, 0, 0, 0); add(10'h000, 0, 0, 0, 0);
    // release bounce
    add(10'h3FF, 0, 0, 0, 0); add(10'h3FF, 0, 0, 0, 0); add(10'h3FF, 1, 1, 0, 0);
    add(10'h000, 1, 0, 0, 0); add(10'h000, 1, 0, 0, 0); add(10'h3FF, 1, 0, 0, 0);
    add(10'h000, 1, 0, 0, 0); add(10'h000, 1, 0, 0, 0); add(10'h000, 0, 0, 1, 0);
    // auto-repeat after hold ticks 4, 6, 8, 10
    add(10'h3FF, 0, 0, 0, 0); add(10'h3FF, 0, 0, 0, 0); add(10'h3FF, 1, 1, 0, 0);
    for (int h = 1; h <= 10; h++) add(10'h3FF, 1, 0, 0, (AR == 1 && h >= 4 && h % 2 == 0) ? 1 : 0);
    add(10'h000, 1, 0, 0, 0); add(10'h000, 1, 0, 0, 0); add(10'h000, 0, 0, 1, 0);
    // short bursts that never reach a sampled tick
    for (int h = 0; h < 4; h++) add(10'h1C0, 0, 0, 0, 0);

    rst_n = 1'b0; btn_raw = 1'b1; tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    check("reset_level", int'(btn_level), 0);
    check("reset_press", int'(press_pulse), 0);
    check("reset_release", int'(release_pulse), 0);
    check("reset_repeat", int'(repeat_pulse), 0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_slot(vecs[k].pat, al, ap, ar, arep);
      check($sformatf("vec%0d_level", k), al, vecs[k].lvl);
      check($sformatf("vec%0d_press", k), ap, vecs[k].np);
      check($sformatf("vec%0d_release", k), ar, vecs[k].nr);
      check($sformatf("vec%0d_repeat", k), arep, vecs[k].nrep);
    end

    // reset mid CONFIRM_PRESS
    slot_check("cp_a", 10'h3FF, 0, 0, 0);
    slot_check("cp_b", 10'h3FF, 0, 0, 0);
    rst_n = 1'b0;
    rel_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rel_cnt += int'(release_pulse) + int'(press_pulse);
    end
    check("rst_cp_pulses", rel_cnt, 0);
    check("rst_cp_level", int'(btn_level), 0);
    rst_n = 1'b1;
    slot_check("redetect1_a", 10'h3FF, 0, 0, 0);
    slot_check("redetect1_b", 10'h3FF, 0, 0, 0);
    slot_check("redetect1_c", 10'h3FF, 1, 1, 0);

    // asynchronous reset mid HELD, away from any clock edge
    #2 rst_n = 1'b0;
    #1 check("rst_held_level_now", int'(btn_level), 0);
    rel_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rel_cnt += int'(release_pulse);
    end
    check("rst_held_release", rel_cnt, 0);
    rst_n = 1'b1;
    slot_check("redetect2_a", 10'h3FF, 0, 0, 0);
    slot_check("redetect2_b", 10'h3FF, 0, 0, 0);
    slot_check("redetect2_c", 10'h3FF, 1, 1, 0);
    slot_check("final_rel_a", 10'h000, 1, 0, 0);
    slot_check("final_rel_b", 10'h000, 1, 0, 0);
    slot_check("final_rel_c", 10'h000, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
